// File: rtl/yarp_pkg.sv
// yarp_pkg: shared ALU op_sel encoding, RV32I opcodes and the decoded-entry struct (illegal bit under YARP_DECODE_ILLEGAL_EN)
package yarp_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [31:0] opr_a;
        logic [31:0] opr_b;
        logic [3:0]  op_sel;
        logic [4:0]  rd;
`ifdef YARP_DECODE_ILLEGAL_EN
        logic        illegal;
`endif
    } entry_t;

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? OP_SUB : OP_ADD;
            3'b001:  alu_op = OP_SLL;
            3'b010:  alu_op = OP_SLT;
            3'b011:  alu_op = OP_SLTU;
            3'b100:  alu_op = OP_XOR;
            3'b101:  alu_op = alt ? OP_SRA : OP_SRL;
            3'b110:  alu_op = OP_OR;
            default: alu_op = OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/yarp_decode_fifo.sv
// yarp_decode_fifo: circular BUF_DEPTH-entry FIFO of decoded entries, outputs driven straight from head storage
module yarp_decode_fifo
    import yarp_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   in_valid_i,
    output logic   in_ready_o,
    input  entry_t din_i,
    output logic   out_valid_o,
    input  logic   out_ready_i,
    output entry_t dout_o
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [BUF_DEPTH];
    entry_t        mem_d [BUF_DEPTH];
    logic          push, pop;

    assign in_ready_o  = count_q != CW'(BUF_DEPTH);
    assign out_valid_o = count_q != '0;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign dout_o      = mem_q[rd_ptr_q];

    // next pointers, occupancy and storage write; pointers wrap at the power-of-two depth
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) mem_d[wr_ptr_q] = din_i;
    end

    // state registers; reset clears storage so the head reads as an all-zero ADD entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/yarp_decode_issue.sv
// yarp_decode_issue: RV32I ALU decode into a buffered issue queue; YARP_DECODE_ILLEGAL_EN adds illegal_o
module yarp_decode_issue
    import yarp_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] opr_a_o,
    output logic [31:0] opr_b_o,
    output logic [3:0]  op_sel_o,
`ifdef YARP_DECODE_ILLEGAL_EN
    output logic        illegal_o,
`endif
    output logic [4:0]  rd_o
);

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic       is_r, is_i, is_lui, is_auipc, is_shift, alt, f7_ok, legal;
    entry_t     din, dout;

    assign opcode   = instr_i[6:0];
    assign f3       = instr_i[14:12];
    assign f7       = instr_i[31:25];
    assign is_r     = opcode == OP_RTYPE;
    assign is_i     = opcode == OP_ITYPE;
    assign is_lui   = opcode == OP_LUI;
    assign is_auipc = opcode == OP_AUIPC;
    assign is_shift = f3 == 3'b001 || f3 == 3'b101;
    assign alt      = f7 == 7'b0100000;
    assign f7_ok    = f7 == 7'b0000000 || (alt && (f3 == 3'b000 || f3 == 3'b101));
    assign legal    = (is_r && f7_ok) || (is_i && (!is_shift || f7_ok)) || is_lui || is_auipc;

    // decode into an entry; anything illegal becomes a zero-operand ADD to rd 0
    always_comb begin
        din        = '0;
        din.op_sel = OP_ADD;
        if (legal) begin
            din.opr_a  = is_lui ? 32'd0 : is_auipc ? pc_i : rs1_data_i;
            din.opr_b  = is_r ? rs2_data_i
                       : is_i ? (is_shift ? {27'd0, instr_i[24:20]} : {{20{instr_i[31]}}, instr_i[31:20]})
                       : {instr_i[31:12], 12'd0};
            din.op_sel = (is_r || is_i) ? alu_op(f3, is_r ? alt : (is_shift && instr_i[30])) : OP_ADD;
            din.rd     = instr_i[11:7];
        end
`ifdef YARP_DECODE_ILLEGAL_EN
        din.illegal = !legal;
`endif
    end

    yarp_decode_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .din_i       (din),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .dout_o      (dout)
    );

    assign opr_a_o  = dout.opr_a;
    assign opr_b_o  = dout.opr_b;
    assign op_sel_o = dout.op_sel;
    assign rd_o     = dout.rd;
`ifdef YARP_DECODE_ILLEGAL_EN
    assign illegal_o = dout.illegal;
`endif

endmodule

// File: tb/tb_yarp_decode_issue.sv
// tb_yarp_decode_issue: directed decode, backpressure, wrap and reset checks for yarp_decode_issue
module tb_yarp_decode_issue;
    import yarp_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] opr_a_o;
    logic [31:0] opr_b_o;
    logic [3:0]  op_sel_o;
    logic [4:0]  rd_o;
`ifdef YARP_DECODE_ILLEGAL_EN
    logic        illegal_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    yarp_decode_issue #(.BUF_DEPTH(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .opr_a_o     (opr_a_o),
        .opr_b_o     (opr_b_o),
        .op_sel_o    (op_sel_o),
`ifdef YARP_DECODE_ILLEGAL_EN
        .illegal_o   (illegal_o),
`endif
        .rd_o        (rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [4:0] rd);
        chk({tag, ".valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, ".a"}, opr_a_o, a);
        chk({tag, ".b"}, opr_b_o, b);
        chk({tag, ".op"}, 32'(op_sel_o), 32'(op));
        chk({tag, ".rd"}, 32'(rd_o), 32'(rd));
    endtask

    // push one instruction with out_ready high; head is checked one cycle later, then popped
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
        @(negedge clk);
        in_valid_i = 1'b1;
        instr_i = ins;
        pc_i = pc;
        rs1_data_i = r1;
        rs2_data_i = r2;
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst.valid", 32'(out_valid_o), 32'd0);
        chk("rst.ready", 32'(in_ready_o), 32'd1);
        chk("rst.a", opr_a_o, 32'd0);
        chk("rst.b", opr_b_o, 32'd0);
        chk("rst.op", 32'(op_sel_o), 32'(OP_ADD));
        chk("rst.rd", 32'(rd_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(32'hFFF08293, 32'h0, 32'd5, 32'd0);
        chk_head("addi", 32'd5, 32'hFFFFFFFF, OP_ADD, 5'd5);
        issue(32'h402081B3, 32'h0, 32'd10, 32'd3);
        chk_head("sub", 32'd10, 32'd3, OP_SUB, 5'd3);
        issue(32'h4040D193, 32'h0, 32'h80000000, 32'd0);
        chk_head("srai", 32'h80000000, 32'd4, OP_SRA, 5'd3);
        issue(32'h0040D193, 32'h0, 32'h80000000, 32'd0);
        chk_head("srli", 32'h80000000, 32'd4, OP_SRL, 5'd3);
        issue(32'h123450B7, 32'h0, 32'hDEAD, 32'd0);
        chk_head("lui", 32'd0, 32'h12345000, OP_ADD, 5'd1);
        issue(32'h00001117, 32'h100, 32'hDEAD, 32'd0);
        chk_head("auipc", 32'h100, 32'h1000, OP_ADD, 5'd2);
        issue(32'h0020C233, 32'h0, 32'h0F0F, 32'h00FF);
        chk_head("xor", 32'h0F0F, 32'h00FF, OP_XOR, 5'd4);
        issue(32'hFFE0A293, 32'h0, 32'd7, 32'd0);
        chk_head("slti", 32'd7, 32'hFFFFFFFE, OP_SLT, 5'd5);
        issue(32'h0000007F, 32'h44, 32'd9, 32'd9);
        chk_head("illop", 32'd0, 32'd0, OP_ADD, 5'd0);
`ifdef YARP_DECODE_ILLEGAL_EN
        chk("illop.flag", 32'(illegal_o), 32'd1);
`endif
        issue(32'h022081B3, 32'h0, 32'd9, 32'd9);
        chk_head("mul", 32'd0, 32'd0, OP_ADD, 5'd0);
`ifdef YARP_DECODE_ILLEGAL_EN
        chk("mul.flag", 32'(illegal_o), 32'd1);
        issue(32'h00008293, 32'h0, 32'd1, 32'd0);
        chk("legal.flag", 32'(illegal_o), 32'd0);
`endif
        @(negedge clk);
        chk("drained", 32'(out_valid_o), 32'd0);

        // backpressure: three beats offered against a stalled consumer
        out_ready_i = 1'b0;
        instr_i = 32'h00008293;
        in_valid_i = 1'b1;
        rs1_data_i = 32'd1;
        @(negedge clk);
        chk("bp.ready1", 32'(in_ready_o), 32'd1);
        rs1_data_i = 32'd2;
        @(negedge clk);
        chk("bp.ready2", 32'(in_ready_o), 32'd0);
        rs1_data_i = 32'd3;
        @(negedge clk);
        chk("bp.held", 32'(in_ready_o), 32'd0);
        chk_head("bp.h0", 32'd1, 32'd0, OP_ADD, 5'd5);
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp.reopen", 32'(in_ready_o), 32'd1);
        chk_head("bp.h1", 32'd2, 32'd0, OP_ADD, 5'd5);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk_head("bp.h2", 32'd3, 32'd0, OP_ADD, 5'd5);
        @(negedge clk);
        chk("bp.empty", 32'(out_valid_o), 32'd0);

        // streaming at occupancy one: pointers wrap several times
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                chk("st.a", opr_a_o, 32'(100 + i - 1));
                chk("st.ready", 32'(in_ready_o), 32'd1);
                chk("st.valid", 32'(out_valid_o), 32'd1);
            end
            in_valid_i = 1'b1;
            rs1_data_i = 32'(100 + i);
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        chk("st.last", opr_a_o, 32'd108);
        @(negedge clk);
        chk("st.empty", 32'(out_valid_o), 32'd0);

        // asynchronous reset with two entries buffered
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        rs1_data_i = 32'd55;
        @(negedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("mr.full", 32'(in_ready_o), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mr.valid", 32'(out_valid_o), 32'd0);
        chk("mr.ready", 32'(in_ready_o), 32'd1);
        chk("mr.a", opr_a_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mr.after", 32'(out_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/yarp_decode_issue.md
# yarp_decode_issue

- Decodes RV32I integer ALU instructions (R-type, I-type ALU, LUI, AUIPC) into ALU operands and an ALU operation select.
- Buffers the decoded results in a small FIFO with valid/ready handshakes on both sides.
- Sits between fetch/register-read and the combinational execute stage, and supplies the execute stage's opr_a, opr_b and op_sel.

## Interface
- BUF_DEPTH, 2: output buffer entries; power of two, ≥2.
- clk  in  1  core clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid_i  in  1  upstream offers an instruction.
- in_ready_o  out  1  block can accept; equals (count < BUF_DEPTH), taken from registered state.
- instr_i  in  32  instruction word.
- pc_i  in  32  PC of instr_i.
- rs1_data_i  in  32  register-file value for instr_i[19:15].
- rs2_data_i  in  32  register-file value for instr_i[24:20].
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream consumes head.
- opr_a_o  out  32  ALU operand A.
- opr_b_o  out  32  ALU operand B.
- op_sel_o  out  4  ALU operation, yarp_pkg encoding.
- rd_o  out  5  destination register.
- illegal_o  out  1  present only with YARP_DECODE_ILLEGAL_EN.

## Operation
- Push occurs when in_valid_i && in_ready_o. Pop occurs when out_valid_o && out_ready_i.
- Decode is combinational on the input side. The decoded entry is written at the push edge.
- Opcode 0110011 (R-type): A=rs1_data, B=rs2_data.
  - funct3 000 selects OP_ADD, or OP_SUB when funct7=0100000.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7=0100000; 110 OR; 111 AND.
- Opcode 0010011 (I-type ALU): A=rs1_data, B=sign-extended instr[31:20].
  - Mapping is as for R-type, but there is no SUB.
  - Shifts (SLLI, SRLI, SRAI): B={27'b0, instr[24:20]}. instr[30] selects SRA.
- Opcode 0110111 (LUI): A=0, B={instr[31:12],12'b0}, OP_ADD.
- Opcode 0010111 (AUIPC): A=pc_i, B={instr[31:12],12'b0}, OP_ADD.
- rd = instr[11:7] for all legal instructions.
- Illegal instruction: any other opcode, or an R-type funct7 outside {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {000,101}, or a shift-immediate with funct7 outside the same rule.
- Buffer: circular FIFO with rd_ptr and wr_ptr of log2(BUF_DEPTH) bits. Pointers wrap naturally.
  - count is log2(BUF_DEPTH)+1 bits.
  - Push only: count+1. Pop only: count−1. Both: count unchanged, and both pointers advance.
  - Full (count==BUF_DEPTH): in_ready_o low, so no push can occur. A pop in that cycle makes in_ready_o high on the next cycle; there is no same-cycle pass-through.
  - Empty: out_valid_o low. Output data holds the last head value and is don't-care.
- Output ports are driven directly from the head entry storage.

## Timing
- Latency: a push at edge N makes the entry visible at out_valid_o after edge N (one cycle) when the buffer was empty.
- Throughput: one instruction per cycle when out_ready_i is held high.
- Handshake rules:
  - Upstream must hold instr_i, pc_i and rs*_data_i stable while in_valid_i is high and in_ready_o is low.
  - out_* data stays stable while out_valid_o is high and out_ready_i is low.
- Reset values (asynchronous, on reset_n low): count=0, pointers=0, out_valid_o=0, in_ready_o=1, opr_a_o=opr_b_o=0, op_sel_o=OP_ADD, rd_o=0, illegal_o=0.
- Reset mid-operation: all buffered entries are discarded. No pop or push completes in the cycle reset is asserted.

## Configuration
- YARP_DECODE_ILLEGAL_EN defined:
  - illegal_o is present.
  - An illegal instruction is still pushed, with A=0, B=0, OP_ADD, rd=0, illegal_o=1, so the exception stays in program order.
- YARP_DECODE_ILLEGAL_EN undefined:
  - No illegal_o port and no illegal bit in storage.
  - An illegal instruction is pushed as the NOP A=0, B=0, OP_ADD, rd=0.

## Structure
- yarp_pkg (shared package) holds:
  - op_sel constants OP_ADD..OP_SLT, already shared with execute;
  - new opcode constants OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011, OP_LUI=7'b0110111, OP_AUIPC=7'b0010111;
  - a decoded-entry struct {opr_a, opr_b, op_sel, rd[, illegal]}.
- Sub-module yarp_decode_fifo: a generic BUF_DEPTH FIFO of the entry struct. Decode logic stays in the top module.

## Test plan
- ADDI x5,x1,-1: instr 0xFFF08293, rs1=5 -> next cycle out_valid=1, A=5, B=0xFFFFFFFF, OP_ADD, rd=5.
- SUB x3,x1,x2: instr 0x402081B3, rs1=10, rs2=3 -> A=10, B=3, OP_SUB, rd=3. SRAI x3,x1,4 (0x4040D193) -> B=4, OP_SRA.
- LUI x1,0x12345 (0x123450B7) -> A=0, B=0x12345000. AUIPC with pc=0x100 -> A=0x100, OP_ADD.
- Backpressure:
  - With out_ready=0, push 3 back-to-back beats: in_ready drops after the 2nd acceptance and the 3rd is held.
  - Raising out_ready then drains all 3 in order, and in_ready returns one cycle after the first pop.
- Simultaneous push/pop at count=1 for 8 cycles -> count stays 1, outputs in order, pointers wrap correctly.
- Instr 0x0000007F:
  - with the macro -> illegal_o=1, A=B=0, rd=0;
  - without the macro -> NOP.
- reset_n asserted while 2 entries are buffered -> out_valid=0 immediately and in_ready=1.
